// File: rtl/router_fsm_ctrl_n.sv
// router_fsm_ctrl_n: moves one packet at a time from the single input port into one of NUM_CH output FIFOs.
// Latency: Moore outputs change one clock after the deciding edge; the only input-to-output path is async reset.
// Backpressure: busy stalls the source while it waits, is full or closes a packet; DROP sinks bytes without stalling.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   pkt_valid, din            source packet valid and header address (din used only in DECODE_ADDRESS)
//   fifo_full/fifo_empty      per-channel FIFO status, muxed by the destination address
//   soft_rst                  per-channel soft reset; only the selected channel is honoured
//   parity_done, low_pkt_valid  end-of-packet hints used when resuming after a full FIFO
//   dest_sel                  one-hot latched destination (zero when idle or dropping)
//   wr_en_req                 FIFO write request
//   detect_addr .. drop_pkt   state flags for the synchroniser/register/FIFO-write blocks
//   busy                      stall the source

module router_fsm_ctrl_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int WAIT_TO = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] din,
  input  logic [NUM_CH-1:0] fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_rst,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic [NUM_CH-1:0] dest_sel,
  output logic              wr_en_req,
  output logic              detect_addr,
  output logic              lfd_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_req,
  output logic              drop_pkt,
  output logic              busy
);

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    WAIT_TILL_EMPTY    = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    LOAD_PARITY        = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP               = 4'd8
  } state_t;

  localparam logic [TO_W-1:0] WAIT_LIMIT = TO_W'(WAIT_TO);
  localparam bit              TIMEOUT_EN = (WAIT_TO != 0);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic [TO_W-1:0]   wait_cnt;
  logic [TO_W-1:0]   wait_cnt_nxt;

  logic [ADDR_W-1:0] sel_idx;
  logic              sel_full;
  logic              sel_empty;
  logic              sel_srst;
  logic              din_valid;
  logic              owns_channel;
  logic              srst_hit;
  logic              wait_expired;

  // Channel status mux. While decoding the header the live address is used,
  // afterwards the latched one. Addresses beyond NUM_CH select nothing, which
  // keeps the mux safe when 2**ADDR_W > NUM_CH.
  always_comb begin
    sel_idx   = (state == DECODE_ADDRESS) ? din : addr_q;
    sel_full  = 1'b0;
    sel_empty = 1'b0;
    sel_srst  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_idx == ADDR_W'(i)) begin
        sel_full  = fifo_full[i];
        sel_empty = fifo_empty[i];
        sel_srst  = soft_rst[i];
      end
    end
  end

  assign din_valid    = (int'(din) < NUM_CH);
  // A channel is "owned" while a packet is bound to a real destination;
  // soft reset and dest_sel only apply then.
  assign owns_channel = (state != DECODE_ADDRESS) && (state != DROP);
  assign srst_hit     = owns_channel && sel_srst;
  assign wait_expired = TIMEOUT_EN && (wait_cnt == WAIT_LIMIT);

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    wait_cnt_nxt = wait_cnt;

    case (state)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          addr_nxt = din;
          if (!din_valid) begin
            state_nxt = DROP;
          end else if (sel_empty) begin
            state_nxt = LOAD_FIRST_DATA;
          end else begin
            state_nxt    = WAIT_TILL_EMPTY;
            wait_cnt_nxt = '0;
          end
        end
      end

      WAIT_TILL_EMPTY: begin
        // Empty wins over an expiring timeout in the same cycle.
        if (sel_empty) begin
          state_nxt = LOAD_FIRST_DATA;
        end else if (wait_expired) begin
          state_nxt = DROP;
        end else begin
          wait_cnt_nxt = wait_cnt + TO_W'(1);
        end
      end

      LOAD_FIRST_DATA: state_nxt = LOAD_DATA;

      LOAD_DATA: begin
        if (sel_full) begin
          state_nxt = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          state_nxt = LOAD_PARITY;
        end
      end

      FIFO_FULL_STATE: begin
        if (!sel_full) begin
          state_nxt = LOAD_AFTER_FULL;
        end
      end

      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          state_nxt = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          state_nxt = LOAD_PARITY;
        end else begin
          state_nxt = LOAD_DATA;
        end
      end

      LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;

      CHECK_PARITY_ERROR: begin
        state_nxt = sel_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end

      DROP: begin
        if (!pkt_valid) begin
          state_nxt = DECODE_ADDRESS;
        end
      end

      default: state_nxt = DECODE_ADDRESS;
    endcase

    // Soft reset of the bound channel overrides every other transition.
    if (srst_hit) begin
      state_nxt = DECODE_ADDRESS;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DECODE_ADDRESS;
      addr_q   <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      addr_q   <= addr_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Moore outputs
  always_comb begin
    dest_sel    = '0;
    wr_en_req   = 1'b0;
    detect_addr = 1'b0;
    lfd_state   = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    rst_int_req = 1'b0;
    drop_pkt    = 1'b0;
    busy        = 1'b1;

    if (owns_channel) begin
      for (int i = 0; i < NUM_CH; i++) begin
        dest_sel[i] = (addr_q == ADDR_W'(i));
      end
    end

    case (state)
      DECODE_ADDRESS: begin
        detect_addr = 1'b1;
        busy        = 1'b0;
      end
      LOAD_FIRST_DATA:    lfd_state = 1'b1;
      LOAD_DATA: begin
        wr_en_req = 1'b1;
        busy      = 1'b0;
      end
      FIFO_FULL_STATE:    full_state = 1'b1;
      LOAD_AFTER_FULL: begin
        laf_state = 1'b1;
        wr_en_req = 1'b1;
      end
      LOAD_PARITY:        wr_en_req = 1'b1;
      CHECK_PARITY_ERROR: rst_int_req = 1'b1;
      DROP: begin
        drop_pkt = 1'b1;
        busy     = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_router_fsm_ctrl_n.sv
// tb_router_fsm_ctrl_n: directed scenarios plus randomized traffic against a packet-level model.
// Latency: outputs checked 1 time unit after each rising edge, or mid-cycle for async reset.
// Backpressure: none; the bench drives all inputs freely.

module tb_router_fsm_ctrl_n;

  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 2;
  localparam int WAIT_TO = 4;
  localparam int TO_W    = 8;
  localparam int OW      = NUM_CH + 8;

  // Bit positions inside the packed output vector
  localparam int B_BUSY = 0;
  localparam int B_DROP = 1;
  localparam int B_RSTI = 2;
  localparam int B_FULL = 3;
  localparam int B_LAF  = 4;
  localparam int B_LFD  = 5;
  localparam int B_DET  = 6;
  localparam int B_WR   = 7;
  localparam int B_DEST = 8;

  // Model phases of a packet's life
  localparam int P_IDLE    = 0;
  localparam int P_HEAD    = 1;
  localparam int P_BODY    = 2;
  localparam int P_WAIT    = 3;
  localparam int P_STALL   = 4;
  localparam int P_RESUME  = 5;
  localparam int P_PAR     = 6;
  localparam int P_CHK     = 7;
  localparam int P_DISCARD = 8;

  logic              clk;
  logic              rst;
  logic              pkt_valid;
  logic [ADDR_W-1:0] din;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] soft_rst;
  logic              parity_done;
  logic              low_pkt_valid;
  logic [NUM_CH-1:0] dest_sel;
  logic              wr_en_req;
  logic              detect_addr;
  logic              lfd_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_req;
  logic              drop_pkt;
  logic              busy;
  logic [OW-1:0]     dut_out;

  int n_vec = 0;
  int n_err = 0;

  int m_phase;
  int m_dest;
  int m_waited;

  router_fsm_ctrl_n #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .WAIT_TO(WAIT_TO),
    .TO_W   (TO_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_valid    (pkt_valid),
    .din          (din),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .soft_rst     (soft_rst),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .dest_sel     (dest_sel),
    .wr_en_req    (wr_en_req),
    .detect_addr  (detect_addr),
    .lfd_state    (lfd_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .rst_int_req  (rst_int_req),
    .drop_pkt     (drop_pkt),
    .busy         (busy)
  );

  assign dut_out = {dest_sel, wr_en_req, detect_addr, lfd_state, laf_state,
                    full_state, rst_int_req, drop_pkt, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [OW-1:0] model_out();
    logic [OW-1:0] v;
    v = '0;
    if (m_phase != P_IDLE && m_phase != P_DISCARD) v[B_DEST + m_dest] = 1'b1;
    v[B_WR]   = (m_phase == P_BODY || m_phase == P_PAR || m_phase == P_RESUME);
    v[B_DET]  = (m_phase == P_IDLE);
    v[B_LFD]  = (m_phase == P_HEAD);
    v[B_LAF]  = (m_phase == P_RESUME);
    v[B_FULL] = (m_phase == P_STALL);
    v[B_RSTI] = (m_phase == P_CHK);
    v[B_DROP] = (m_phase == P_DISCARD);
    v[B_BUSY] = !(m_phase == P_IDLE || m_phase == P_BODY || m_phase == P_DISCARD);
    return v;
  endfunction

  task automatic model_reset();
    m_phase  = P_IDLE;
    m_dest   = 0;
    m_waited = 0;
  endtask

  task automatic model_advance();
    int idx;
    bit f;
    bit e;
    bit s;
    idx = (m_phase == P_IDLE) ? int'(din) : m_dest;
    f = 1'b0;
    e = 1'b0;
    s = 1'b0;
    if (idx < NUM_CH) begin
      f = fifo_full[idx];
      e = fifo_empty[idx];
      s = soft_rst[idx];
    end
    if (m_phase != P_IDLE && m_phase != P_DISCARD && s) begin
      m_phase = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE: if (pkt_valid) begin
          m_dest = int'(din);
          if (m_dest >= NUM_CH) m_phase = P_DISCARD;
          else if (e)           m_phase = P_HEAD;
          else begin
            m_phase  = P_WAIT;
            m_waited = 0;
          end
        end
        P_WAIT: begin
          if (e) m_phase = P_HEAD;
          else if (WAIT_TO != 0 && m_waited == WAIT_TO) m_phase = P_DISCARD;
          else m_waited++;
        end
        P_HEAD:    m_phase = P_BODY;
        P_BODY:    if (f) m_phase = P_STALL; else if (!pkt_valid) m_phase = P_PAR;
        P_STALL:   if (!f) m_phase = P_RESUME;
        P_RESUME:  m_phase = parity_done ? P_IDLE : (low_pkt_valid ? P_PAR : P_BODY);
        P_PAR:     m_phase = P_CHK;
        P_CHK:     m_phase = f ? P_STALL : P_IDLE;
        P_DISCARD: if (!pkt_valid) m_phase = P_IDLE;
        default:   m_phase = P_IDLE;
      endcase
    end
  endtask

  // Advance model and DUT by one clock, then settle before sampling.
  task automatic tick();
    if (!rst) model_reset();
    else      model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_inputs();
    pkt_valid     = 1'b0;
    din           = '0;
    fifo_full     = '0;
    fifo_empty    = '0;
    soft_rst      = '0;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [OW-1:0] want;
    rst = 1'b0;
    set_idle_inputs();
    model_reset();
    #1;
    want = '0;
    want[B_DET] = 1'b1;
    n_vec++;
    if (dut_out !== want) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want %b", dut_out, want);
    end
    tick();
    n_vec++;
    if (dut_out !== model_out()) begin
      n_err++;
      $display("FAIL reset_held: got %b want %b", dut_out, model_out());
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (detect_addr !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: detect=%b busy=%b want detect=1 busy=0", detect_addr, busy);
    end
  endtask

  task automatic test_single_packet();
    set_idle_inputs();
    pkt_valid  = 1'b1;
    din        = 2'd2;
    fifo_empty = 3'b100;
    tick();
    n_vec++;
    if (lfd_state !== 1'b1 || dest_sel !== 3'b100 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL pkt_lfd: lfd=%b dest=%b busy=%b want 1 100 1", lfd_state, dest_sel, busy);
    end
    tick();
    n_vec++;
    if (wr_en_req !== 1'b1 || busy !== 1'b0 || dest_sel !== 3'b100) begin
      n_err++;
      $display("FAIL pkt_data: wr=%b busy=%b dest=%b want 1 0 100", wr_en_req, busy, dest_sel);
    end
    pkt_valid = 1'b0;
    tick();
    n_vec++;
    if (dut_out !== model_out() || wr_en_req !== 1'b1) begin
      n_err++;
      $display("FAIL pkt_parity: got %b want %b", dut_out, model_out());
    end
    tick();
    n_vec++;
    if (rst_int_req !== 1'b1) begin
      n_err++;
      $display("FAIL pkt_check: rst_int_req=%b want 1", rst_int_req);
    end
    tick();
    n_vec++;
    if (detect_addr !== 1'b1 || dest_sel !== 3'b000) begin
      n_err++;
      $display("FAIL pkt_done: detect=%b dest=%b want 1 000", detect_addr, dest_sel);
    end
  endtask

  task automatic test_dest_full();
    logic [OW-1:0] want;
    set_idle_inputs();
    pkt_valid  = 1'b1;
    din        = 2'd1;
    fifo_empty = 3'b010;
    tick();
    tick();
    fifo_full = 3'b010;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (full_state !== 1'b1 || busy !== 1'b1 || wr_en_req !== 1'b0) begin
        n_err++;
        $display("FAIL full_hold[%0d]: full=%b busy=%b wr=%b want 1 1 0", i, full_state, busy, wr_en_req);
      end
    end
    fifo_full = 3'b000;
    tick();
    n_vec++;
    if (laf_state !== 1'b1 || wr_en_req !== 1'b1) begin
      n_err++;
      $display("FAIL full_laf: laf=%b wr=%b want 1 1", laf_state, wr_en_req);
    end
    low_pkt_valid = 1'b1;
    tick();
    want = '0;
    want[B_DEST+1] = 1'b1;
    want[B_WR]     = 1'b1;
    want[B_BUSY]   = 1'b1;
    n_vec++;
    if (dut_out !== want) begin
      n_err++;
      $display("FAIL full_low_pkt: got %b want %b", dut_out, want);
    end
    low_pkt_valid = 1'b0;
    pkt_valid     = 1'b0;
    tick();
    tick();
    // second packet: parity_done outranks low_pkt_valid
    pkt_valid = 1'b1;
    tick();
    tick();
    fifo_full = 3'b010;
    tick();
    fifo_full = 3'b000;
    tick();
    parity_done   = 1'b1;
    low_pkt_valid = 1'b1;
    pkt_valid     = 1'b0;
    tick();
    n_vec++;
    if (detect_addr !== 1'b1 || dut_out !== model_out()) begin
      n_err++;
      $display("FAIL full_parity_done: got %b want %b", dut_out, model_out());
    end
    set_idle_inputs();
  endtask

  task automatic test_invalid_addr();
    set_idle_inputs();
    pkt_valid  = 1'b1;
    din        = 2'd3;
    fifo_empty = 3'b111;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (drop_pkt !== 1'b1 || wr_en_req !== 1'b0 || dest_sel !== 3'b000 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL drop[%0d]: drop=%b wr=%b dest=%b busy=%b want 1 0 000 0",
                 i, drop_pkt, wr_en_req, dest_sel, busy);
      end
    end
    pkt_valid = 1'b0;
    tick();
    n_vec++;
    if (detect_addr !== 1'b1 || drop_pkt !== 1'b0) begin
      n_err++;
      $display("FAIL drop_exit: detect=%b drop=%b want 1 0", detect_addr, drop_pkt);
    end
  endtask

  task automatic test_wait_path();
    set_idle_inputs();
    pkt_valid = 1'b1;
    din       = 2'd0;
    for (int i = 0; i < WAIT_TO + 1; i++) begin
      tick();
      n_vec++;
      if (busy !== 1'b1 || drop_pkt !== 1'b0 || lfd_state !== 1'b0 || dest_sel !== 3'b001) begin
        n_err++;
        $display("FAIL wait_cycle[%0d]: busy=%b drop=%b lfd=%b dest=%b want 1 0 0 001",
                 i, busy, drop_pkt, lfd_state, dest_sel);
      end
    end
    tick();
    n_vec++;
    if (drop_pkt !== 1'b1) begin
      n_err++;
      $display("FAIL wait_timeout: drop=%b want 1", drop_pkt);
    end
    pkt_valid = 1'b0;
    tick();
    // empty arrives on the third wait cycle
    pkt_valid = 1'b1;
    tick();
    tick();
    tick();
    fifo_empty = 3'b001;
    tick();
    n_vec++;
    if (lfd_state !== 1'b1) begin
      n_err++;
      $display("FAIL wait_empty: lfd=%b want 1", lfd_state);
    end
    pkt_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    // empty arriving on the very cycle the timeout expires still wins
    fifo_empty = 3'b000;
    pkt_valid  = 1'b1;
    for (int i = 0; i < WAIT_TO + 1; i++) tick();
    fifo_empty = 3'b001;
    tick();
    n_vec++;
    if (lfd_state !== 1'b1 || drop_pkt !== 1'b0) begin
      n_err++;
      $display("FAIL wait_empty_vs_timeout: lfd=%b drop=%b want 1 0", lfd_state, drop_pkt);
    end
    pkt_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_vec++;
    if (dut_out !== model_out() || detect_addr !== 1'b1) begin
      n_err++;
      $display("FAIL wait_finish: got %b want %b", dut_out, model_out());
    end
    set_idle_inputs();
  endtask

  task automatic test_soft_rst();
    set_idle_inputs();
    pkt_valid  = 1'b1;
    din        = 2'd1;
    fifo_empty = 3'b010;
    tick();
    tick();
    soft_rst = 3'b010;
    tick();
    n_vec++;
    if (detect_addr !== 1'b1 || wr_en_req !== 1'b0) begin
      n_err++;
      $display("FAIL srst_selected: detect=%b wr=%b want 1 0", detect_addr, wr_en_req);
    end
    soft_rst = 3'b000;
    tick();
    tick();
    soft_rst = 3'b001;
    tick();
    n_vec++;
    if (wr_en_req !== 1'b1 || detect_addr !== 1'b0 || dest_sel !== 3'b010) begin
      n_err++;
      $display("FAIL srst_other: wr=%b detect=%b dest=%b want 1 0 010", wr_en_req, detect_addr, dest_sel);
    end
    soft_rst  = 3'b000;
    pkt_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_vec++;
    if (dut_out !== model_out() || detect_addr !== 1'b1) begin
      n_err++;
      $display("FAIL srst_finish: got %b want %b", dut_out, model_out());
    end
  endtask

  task automatic test_async_rst();
    set_idle_inputs();
    pkt_valid  = 1'b1;
    din        = 2'd0;
    fifo_empty = 3'b001;
    tick();
    tick();
    fifo_full = 3'b001;
    tick();
    n_vec++;
    if (full_state !== 1'b1) begin
      n_err++;
      $display("FAIL arst_pre: full_state=%b want 1", full_state);
    end
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (full_state !== 1'b0 || detect_addr !== 1'b1 || dest_sel !== 3'b000) begin
      n_err++;
      $display("FAIL arst_immediate: full=%b detect=%b dest=%b want 0 1 000", full_state, detect_addr, dest_sel);
    end
    set_idle_inputs();
    #2;
    rst = 1'b1;
    tick();
    n_vec++;
    if (dut_out !== model_out()) begin
      n_err++;
      $display("FAIL arst_after: got %b want %b", dut_out, model_out());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      pkt_valid     = ($urandom_range(0, 3) != 0);
      din           = ADDR_W'($urandom_range(0, 3));
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < NUM_CH; b++) begin
        fifo_full[b]  = ($urandom_range(0, 3) == 0);
        fifo_empty[b] = ($urandom_range(0, 1) == 0);
        soft_rst[b]   = ($urandom_range(0, 15) == 0);
      end
      rst = ($urandom_range(0, 199) != 0);
      tick();
      n_vec++;
      if (dut_out !== model_out()) begin
        n_err++;
        $display("FAIL random[%0d]: got %b want %b (phase %0d)", i, dut_out, model_out(), m_phase);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_dest_full();
    test_invalid_addr();
    test_wait_path();
    test_soft_rst();
    test_async_rst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
